// File: rtl/insmem_loader.sv
// Framed byte-stream loader for the instruction memory write port.
// Holds the core in reset until a length/payload/checksum frame is accepted.
module insmem_loader #(
   parameter int                 MEM_BYTES = 400,
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [15:0]       bytes_written
);

   typedef enum logic [2:0] {
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [15:0]       bw_q, bw_d;
   logic [15:0]       length_q, length_d;
   logic [7:0]        csum_q, csum_d;

   logic        accept;
   logic [15:0] len_full;
   logic        len_big;
   logic        len_odd;

   assign accept   = in_valid && in_ready_q;
   assign len_full = {in_data, length_q[7:0]};
   assign len_big  = 32'(len_full) > 32'(MEM_BYTES);
   assign len_odd  = len_full[1:0] != 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LEN_LO;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= BASE_ADDR;
         wr_data_q  <= 8'h00;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         bw_q       <= 16'd0;
         length_q   <= 16'd0;
         csum_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         bw_q       <= bw_d;
         length_q   <= length_d;
         csum_q     <= csum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LEN_LO: if (accept) state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (len_big || len_odd)   state_d = S_ERR;
               else if (len_full == 0)   state_d = S_CSUM;
               else                      state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && (bw_q + 16'd1 == length_q))
               state_d = S_CSUM;
         end
         S_CSUM: begin
            if (accept)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: if (restart) state_d = S_LEN_LO;
         default: state_d = S_LEN_LO;
      endcase
   end

   // Status flags are registered copies of the next state.
   always_comb begin
      length_d   = length_q;
      csum_d     = csum_q;
      bw_d       = bw_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_code_d = err_code_q;
      unique case (state_q)
         S_LEN_LO: if (accept) length_d[7:0] = in_data;
         S_LEN_HI: begin
            if (accept) begin
               length_d[15:8] = in_data;
               if (len_big)      err_code_d = 2'd1;
               else if (len_odd) err_code_d = 2'd2;
            end
         end
         S_DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = BASE_ADDR + ADDR_W'(bw_q);
               wr_data_d = in_data;
               csum_d    = csum_q ^ in_data;
               bw_d      = bw_q + 16'd1;
            end
         end
         S_CSUM: begin
            if (accept && (in_data != csum_q)) err_code_d = 2'd3;
         end
         S_DONE, S_ERR: begin
            if (restart) begin
               err_code_d = 2'd0;
               bw_d       = 16'd0;
               csum_d     = 8'h00;
            end
         end
         default: ;
      endcase
      in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
      done_d     = state_d == S_DONE;
      err_d      = state_d == S_ERR;
      cpu_hold_d = state_d != S_DONE;
   end

   assign in_ready      = in_ready_q;
   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign cpu_hold      = cpu_hold_q;
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign bytes_written = bw_q;

endmodule

// File: tb/tb_insmem_loader.sv
// Directed bench for insmem_loader: frames, gaps, length errors,
// checksum error and mid-load reset, with a write-port monitor.
module tb_insmem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        restart;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] bytes_written;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] qa[$];
   logic [7:0]  qd[$];
   int          qc[$];

   logic [7:0] frame[$];
   logic [7:0] pay8[$];

   insmem_loader dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .restart(restart),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .err(err),
      .err_code(err_code), .bytes_written(bytes_written)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         qa.push_back(wr_addr);
         qd.push_back(wr_data);
         qc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      qa.delete();
      qd.delete();
      qc.delete();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f[$], input bit gaps);
      foreach (f[i]) send(f[i], gaps ? int'($urandom_range(0, 3)) : 0);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic chk_pay8(input string tag, input bit tight);
      chk({tag, "_nwr"}, qa.size(), 8);
      if (qa.size() == 8) begin
         foreach (pay8[i]) begin
            chk({tag, "_addr"}, qa[i], i);
            chk({tag, "_data"}, qd[i], pay8[i]);
         end
         if (tight) chk({tag, "_b2b"}, qc[7] - qc[0], 7);
      end
   endtask

   initial begin
      logic [7:0] x;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;
      pay8 = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h93, 8'h02, 8'h20, 8'h00};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_bw", bytes_written, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_wdata", wr_data, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);

      // N=8, in_valid held high
      clr_mon();
      frame = '{8'h08, 8'h00};
      foreach (pay8[i]) frame.push_back(pay8[i]);
      frame.push_back(8'h72);
      send_frame(frame, 1'b0);
      chk("t1_done", done, 1);
      chk("t1_hold", cpu_hold, 0);
      chk("t1_err", err, 0);
      chk("t1_bw", bytes_written, 8);
      chk("t1_ready", in_ready, 0);
      chk_pay8("t1", 1'b1);
      pulse_restart();
      chk("rs1_done", done, 0);
      chk("rs1_hold", cpu_hold, 1);
      chk("rs1_bw", bytes_written, 0);
      chk("rs1_ready", in_ready, 1);

      // same frame with gaps
      clr_mon();
      send_frame(frame, 1'b1);
      repeat (3) @(negedge clk);
      chk("t2_done", done, 1);
      chk("t2_hold", cpu_hold, 0);
      chk("t2_bw", bytes_written, 8);
      chk_pay8("t2", 1'b0);
      pulse_restart();

      // length 404
      clr_mon();
      frame = '{8'h94, 8'h01};
      send_frame(frame, 1'b0);
      chk("t3_err", err, 1);
      chk("t3_code", err_code, 1);
      chk("t3_ready", in_ready, 0);
      chk("t3_hold", cpu_hold, 1);
      pulse_restart();
      chk("t3_nwr", qa.size(), 0);
      chk("rs3_err", err, 0);
      chk("rs3_code", err_code, 0);
      chk("rs3_ready", in_ready, 1);

      // length 409: both checks fail
      frame = '{8'h99, 8'h01};
      send_frame(frame, 1'b0);
      chk("t3b_code", err_code, 1);
      pulse_restart();

      // length 6
      clr_mon();
      frame = '{8'h06, 8'h00};
      send_frame(frame, 1'b0);
      repeat (2) @(negedge clk);
      chk("t4_err", err, 1);
      chk("t4_code", err_code, 2);
      chk("t4_nwr", qa.size(), 0);
      pulse_restart();

      // length 0
      clr_mon();
      frame = '{8'h00, 8'h00, 8'h00};
      send_frame(frame, 1'b0);
      chk("t5_done", done, 1);
      chk("t5_hold", cpu_hold, 0);
      chk("t5_bw", bytes_written, 0);
      chk("t5_nwr", qa.size(), 0);
      pulse_restart();

      // checksum mismatch
      clr_mon();
      frame = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(frame, 1'b0);
      chk("t6_err", err, 1);
      chk("t6_code", err_code, 3);
      chk("t6_hold", cpu_hold, 1);
      chk("t6_done", done, 0);
      chk("t6_nwr", qa.size(), 4);
      if (qa.size() == 4) chk("t6_d0", qd[0], 8'h13);
      pulse_restart();

      // maximum length 400
      clr_mon();
      frame = '{8'h90, 8'h01};
      x = 8'h00;
      for (int i = 0; i < 400; i++) begin
         frame.push_back(8'(i));
         x ^= 8'(i);
      end
      frame.push_back(x);
      send_frame(frame, 1'b0);
      chk("t7_done", done, 1);
      chk("t7_bw", bytes_written, 400);
      chk("t7_nwr", qa.size(), 400);
      if (qa.size() == 400) begin
         chk("t7_last_addr", qa[399], 399);
         chk("t7_last_data", qd[399], 8'h8f);
      end
      pulse_restart();

      // reset after 3 payload bytes
      clr_mon();
      frame = '{8'h08, 8'h00, 8'h93, 8'h00, 8'h50};
      send_frame(frame, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("t8_wr_en", wr_en, 0);
      chk("t8_bw", bytes_written, 0);
      chk("t8_ready", in_ready, 0);
      chk("t8_nwr", qa.size(), 3);
      rst = 1'b0;
      @(negedge clk);
      clr_mon();
      frame = '{8'h08, 8'h00};
      foreach (pay8[i]) frame.push_back(pay8[i]);
      frame.push_back(8'h72);
      send_frame(frame, 1'b0);
      chk("t8_done", done, 1);
      chk_pay8("t8", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/insmem_loader.md
Name: insmem_loader

Overview:
- Write-side companion to the byte-wide instruction memory: accepts a framed byte stream (length, payload, checksum) and emits one byte-write per payload byte into the instruction store.
- Holds the core in reset (cpu_hold) until a complete, valid image is loaded.
- Sits between a byte source (UART RX, testbench, debug port) and the instruction memory write port.

Parameters:
- MEM_BYTES, 400, capacity of the instruction memory in bytes; the largest legal image length.
- ADDR_W, 32, width of wr_addr; matches the core address width.
- BASE_ADDR, 0, byte address written by the first payload byte.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte; a byte transfers on a cycle with in_valid && in_ready
- restart  in  1  single-cycle pulse; leaves DONE/ERR for a new load
- wr_en  out  1  one-cycle byte-write strobe
- wr_addr  out  ADDR_W  byte address of the write
- wr_data  out  8  byte to write
- cpu_hold  out  1  core held in reset while high
- done  out  1  valid image loaded
- err  out  1  load failed
- err_code  out  2  0 none, 1 length > MEM_BYTES, 2 length not a multiple of 4, 3 checksum mismatch
- bytes_written  out  16  payload bytes written in the current load

Behaviour:
- Reset values: state LEN_LO; in_ready 0 in the reset cycle, then 1; wr_en 0; wr_addr BASE_ADDR; wr_data 0; cpu_hold 1; done 0; err 0; err_code 0; bytes_written 0; length 0; csum 0.
- Frame format: LEN_LO, LEN_HI (16-bit little-endian byte count N), N payload bytes, then 1 checksum byte equal to the XOR of all payload bytes.
- States and transitions:
  - LEN_LO: on accept, latch length[7:0]; go to LEN_HI.
  - LEN_HI: on accept, latch length[15:8], then check the full length N:
    - N > MEM_BYTES: go to ERR, err_code 1.
    - N[1:0] != 0: go to ERR, err_code 2. If both checks fail, err_code is 1.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: on each accept, on the next cycle: wr_en=1, wr_addr=BASE_ADDR+bytes_written (pre-increment value), wr_data=byte. Also update csum^=byte and increment bytes_written. Go to CSUM after the Nth byte.
  - CSUM: on accept, compare the byte with csum. Match: go to DONE. Mismatch: go to ERR, err_code 3.
  - DONE: in_ready=0; done=1; cpu_hold=0.
  - ERR: in_ready=0; err=1; cpu_hold=1.
  - restart in DONE or ERR: go to LEN_LO next cycle. Clears done, err, err_code, bytes_written and csum; cpu_hold returns to 1. restart is ignored in every other state.
- Output timing:
  - Write latency is exactly 1 cycle after acceptance; all outputs are registered.
  - wr_en is never high for two cycles from one byte.
  - Back-to-back accepts produce back-to-back writes.
  - done and err rise the cycle after the checksum byte (or LEN_HI) is accepted.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 otherwise. Gaps in in_valid stall the FSM without side effects.
- Addresses never exceed BASE_ADDR+MEM_BYTES-1, because length is checked before any write.
- Reset mid-load: all state returns to reset values next cycle and no wr_en is issued. Memory contents already written are not touched.
- No combinational path from in_valid to in_ready.

Test Plan:
- Load N=8 (stream 08 00 93 00 50 00 93 02 20 00, then 72) with in_valid held high -> 8 wr_en pulses on consecutive cycles, addresses 0..7 with data 93,00,50,00,93,02,20,00; done=1 and cpu_hold=0 the cycle after 72 is accepted; bytes_written=8.
- Same frame with random 0-3 cycle gaps on in_valid -> identical write sequence and final state; no extra wr_en pulses.
- Length 0x0194 (404) -> err=1, err_code=1, no wr_en, in_ready=0; a following restart pulse -> LEN_LO, err=0, in_ready=1.
- Length 6 -> err_code=2, no writes. Length 0 with checksum 00 -> done, with zero writes.
- N=4 payload 13 00 00 00 with checksum 00 -> 4 writes, then err_code=3, cpu_hold stays 1.
- rst asserted after 3 payload bytes -> next cycle state LEN_LO, bytes_written=0, wr_en=0. A fresh valid frame then loads from address 0 and reaches done.
